// File: rtl/mole_field_ctrl.sv
// mole_field_ctrl
// Game-field controller for the target-lamp game. Lights lamps from the
// LFSR pattern on spawn ticks, ages them out, scores button hits, counts
// misses and times the round (IDLE -> RUN -> OVER).
//
// Optional build macro:
//   MISS_PENALTY_EN - in RUN, a press on an unlit lane subtracts 1 from the
//                     score (saturating at 0), applied after hits are added.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tick       in   one-clk game-timebase pulse
//   start      in   one-clk pulse that begins a round from IDLE/OVER
//   prn[4:0]   in   lane-select pattern
//   spawn_t    in   spawn trigger (qualified by tick)
//   btn[4:0]   in   one-clk press pulses, one per lane
//   lamp[4:0]  out  lit-target lamps
//   score[7:0] out  hit count, saturating
//   miss[7:0]  out  expired-target count, saturating
//   time_left  out  remaining round ticks (16 bits)
//   game_over  out  high in OVER
module mole_field_ctrl #(
    parameter int LIFE_TICKS = 8,
    parameter int GAME_TICKS = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic [4:0]  prn,
    input  logic        spawn_t,
    input  logic [4:0]  btn,
    output logic [4:0]  lamp,
    output logic [7:0]  score,
    output logic [7:0]  miss,
    output logic [15:0] time_left,
    output logic        game_over
);

    localparam int LW = $clog2(LIFE_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          lamp_q, lamp_d;
    logic [7:0]          score_q, score_d;
    logic [7:0]          miss_q, miss_d;
    logic [15:0]         time_q, time_d;
    logic                over_q, over_d;
    logic [4:0][LW-1:0]  life_q, life_d;

    logic [4:0]          hit;
    logic [4:0]          expire;
    logic [4:0]          spawn;
    logic                last_tick;

    function automatic logic [2:0] popcnt5(input logic [4:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 5; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {6'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [2:0] n);
        return (a < {5'b0, n}) ? 8'h00 : (a - {5'b0, n});
    endfunction

    always_comb begin
        state_d   = state_q;
        lamp_d    = lamp_q;
        score_d   = score_q;
        miss_d    = miss_q;
        time_d    = time_q;
        over_d    = over_q;
        life_d    = life_q;
        hit       = 5'b0;
        expire    = 5'b0;
        spawn     = 5'b0;
        last_tick = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_RUN;
                    lamp_d  = 5'b0;
                    score_d = 8'd0;
                    miss_d  = 8'd0;
                    time_d  = 16'(GAME_TICKS);
                    over_d  = 1'b0;
                    life_d  = '0;
                end
            end

            S_RUN: begin
                // Hits take priority over expiry and spawn on the same lane.
                hit     = btn & lamp_q;
                score_d = sat_add8(score_q, popcnt5(hit));
`ifdef MISS_PENALTY_EN
                score_d = sat_sub8(score_d, popcnt5(btn & ~lamp_q));
`endif
                lamp_d  = lamp_q & ~hit;
                for (int i = 0; i < 5; i++) begin
                    if (hit[i]) begin
                        life_d[i] = '0;
                    end
                end

                if (tick) begin
                    time_d    = time_q - 16'd1;
                    last_tick = (time_q == 16'd1);
                    for (int i = 0; i < 5; i++) begin
                        if (lamp_q[i] && !hit[i]) begin
                            if (life_q[i] == LW'(1)) begin
                                expire[i] = 1'b1;
                            end else begin
                                life_d[i] = life_q[i] - LW'(1);
                            end
                        end
                    end

                    if (last_tick) begin
                        // Round end clears the field silently: no misses, no spawn.
                        lamp_d  = 5'b0;
                        life_d  = '0;
                        state_d = S_OVER;
                        over_d  = 1'b1;
                    end else begin
                        miss_d = sat_add8(miss_q, popcnt5(expire));
                        lamp_d = lamp_d & ~expire;
                        // Only lanes dark at the start of the cycle may light,
                        // so a lane hit or expired now is not relit.
                        if (spawn_t) begin
                            spawn = prn & ~lamp_q;
                        end
                        lamp_d = lamp_d | spawn;
                        for (int i = 0; i < 5; i++) begin
                            if (expire[i]) begin
                                life_d[i] = '0;
                            end
                            if (spawn[i]) begin
                                life_d[i] = LW'(LIFE_TICKS);
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lamp_q  <= 5'b0;
            score_q <= 8'd0;
            miss_q  <= 8'd0;
            time_q  <= 16'd0;
            over_q  <= 1'b0;
            life_q  <= '0;
        end else begin
            state_q <= state_d;
            lamp_q  <= lamp_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            time_q  <= time_d;
            over_q  <= over_d;
            life_q  <= life_d;
        end
    end

    assign lamp      = lamp_q;
    assign score     = score_q;
    assign miss      = miss_q;
    assign time_left = time_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Self-checking bench for mole_field_ctrl: directed scenarios with literal
// expectations, followed by randomized stimulus compared every cycle against
// a tick-count based behavioural model.
module tb_mole_field_ctrl;

    localparam int LT = 4;
    localparam int GT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  prn = 5'b0;
    logic        spawn_t = 1'b0;
    logic [4:0]  btn = 5'b0;
    logic [4:0]  lamp;
    logic [7:0]  score;
    logic [7:0]  miss;
    logic [15:0] time_left;
    logic        game_over;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a lamp is described by the absolute round tick on
    // which it will expire, rather than by a countdown.
    bit       m_run = 1'b0;
    bit       m_over = 1'b0;
    bit [4:0] m_lamp = 5'b0;
    int       m_exp_at[5];
    int       m_ticks = 0;
    int       m_score = 0;
    int       m_miss = 0;
    int       m_time = 0;

    always #5 clk = ~clk;

    mole_field_ctrl #(.LIFE_TICKS(LT), .GAME_TICKS(GT)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .prn(prn),
        .spawn_t(spawn_t), .btn(btn), .lamp(lamp), .score(score),
        .miss(miss), .time_left(time_left), .game_over(game_over)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int nh;
        int np;
        bit last;
        bit [4:0] lamp0;
        bit [4:0] nl;
        if (rst) begin
            m_run = 0; m_over = 0; m_lamp = 0;
            m_score = 0; m_miss = 0; m_time = 0; m_ticks = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_over = 0; m_lamp = 0;
                m_score = 0; m_miss = 0; m_time = GT; m_ticks = 0;
            end
        end else begin
            lamp0 = m_lamp;
            nl = lamp0;
            nh = 0;
            np = 0;
            for (int i = 0; i < 5; i++) begin
                if (btn[i]) begin
                    if (lamp0[i]) begin nh++; nl[i] = 0; end
                    else np++;
                end
            end
            m_score = (m_score + nh > 255) ? 255 : m_score + nh;
`ifdef MISS_PENALTY_EN
            m_score = (m_score - np < 0) ? 0 : m_score - np;
`endif
            if (tick) begin
                m_ticks++;
                last = (m_time == 1);
                m_time--;
                if (last) begin
                    nl = 0; m_run = 0; m_over = 1;
                end else begin
                    for (int i = 0; i < 5; i++) begin
                        if (nl[i] && m_ticks == m_exp_at[i]) begin
                            nl[i] = 0;
                            m_miss = (m_miss >= 255) ? 255 : m_miss + 1;
                        end
                    end
                    if (spawn_t) begin
                        for (int i = 0; i < 5; i++) begin
                            if (prn[i] && !lamp0[i]) begin
                                nl[i] = 1;
                                m_exp_at[i] = m_ticks + LT;
                            end
                        end
                    end
                end
            end
            m_lamp = nl;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_lamp", int'(lamp), int'(m_lamp));
            chk("model_score", int'(score), m_score);
            chk("model_miss", int'(miss), m_miss);
            chk("model_time_left", int'(time_left), m_time);
            chk("model_game_over", int'(game_over), int'(m_over));
        end
    end

    task automatic step(input bit st, input bit tk, input bit sp,
                        input logic [4:0] p, input logic [4:0] b);
        start = st; tick = tk; spawn_t = sp; prn = p; btn = b;
        @(negedge clk);
        start = 0; tick = 0; spawn_t = 0; prn = 5'b0; btn = 5'b0;
    endtask

    initial begin
        int s_hold;
        for (int i = 0; i < 5; i++) m_exp_at[i] = 0;
        @(negedge clk);

        // Reset
        rst = 1;
        step(0, 0, 0, 5'b0, 5'b0);
        step(0, 0, 0, 5'b0, 5'b0);
        rst = 0;
        chk_en = 1;
        chk("rst_lamp", int'(lamp), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_miss", int'(miss), 0);
        chk("rst_time_left", int'(time_left), 0);
        chk("rst_game_over", int'(game_over), 0);

        // Round 1
        step(1, 0, 0, 5'b0, 5'b0);
        chk("start_time_left", int'(time_left), 10);
        step(0, 1, 1, 5'b10101, 5'b0);
        chk("spawn1_lamp", int'(lamp), 5'b10101);
        chk("spawn1_time_left", int'(time_left), 9);
        step(0, 0, 0, 5'b0, 5'b00101);
        chk("hit_lamp", int'(lamp), 5'b10000);
        chk("hit_score", int'(score), 2);
        step(0, 0, 0, 5'b0, 5'b10000);
        step(0, 0, 0, 5'b0, 5'b10000);
        step(0, 0, 0, 5'b0, 5'b10000);
`ifdef MISS_PENALTY_EN
        s_hold = 1;
`else
        s_hold = 3;
`endif
        chk("hold_score", int'(score), s_hold);
        chk("hold_lamp", int'(lamp), 0);

        step(0, 1, 1, 5'b00011, 5'b0);
        chk("spawn2_lamp", int'(lamp), 5'b00011);
        step(0, 1, 0, 5'b0, 5'b0);
        step(0, 1, 0, 5'b0, 5'b0);
        step(0, 1, 0, 5'b0, 5'b0);
        chk("pre_expiry_lamp", int'(lamp), 5'b00011);
        step(0, 1, 0, 5'b0, 5'b0);
        chk("expiry_lamp", int'(lamp), 0);
        chk("expiry_miss", int'(miss), 2);
        chk("expiry_time_left", int'(time_left), 4);

        step(0, 1, 1, 5'b10101, 5'b0);
        step(0, 1, 1, 5'b00111, 5'b0);
        chk("spawn_merge_lamp", int'(lamp), 5'b10111);
        step(0, 1, 0, 5'b0, 5'b0);
        chk("pre_final_time_left", int'(time_left), 1);
        step(0, 1, 0, 5'b0, 5'b00001);
        chk("final_lamp", int'(lamp), 0);
        chk("final_score", int'(score), s_hold + 1);
        chk("final_miss", int'(miss), 2);
        chk("final_game_over", int'(game_over), 1);
        chk("final_time_left", int'(time_left), 0);
        step(0, 1, 1, 5'b11111, 5'b11111);
        step(0, 1, 1, 5'b11111, 5'b11111);
        chk("over_hold_score", int'(score), s_hold + 1);
        chk("over_hold_lamp", int'(lamp), 0);
        chk("over_hold_game_over", int'(game_over), 1);

        // Round 2
        step(1, 0, 0, 5'b0, 5'b0);
        chk("restart_score", int'(score), 0);
        chk("restart_miss", int'(miss), 0);
        chk("restart_time_left", int'(time_left), 10);
        chk("restart_game_over", int'(game_over), 0);
        step(0, 1, 1, 5'b00011, 5'b0);
        step(0, 1, 0, 5'b0, 5'b0);
        step(0, 1, 0, 5'b0, 5'b0);
        step(0, 1, 0, 5'b0, 5'b0);
        step(0, 1, 0, 5'b0, 5'b00001);
        chk("hit_vs_expiry_score", int'(score), 1);
        chk("hit_vs_expiry_miss", int'(miss), 1);
        chk("hit_vs_expiry_lamp", int'(lamp), 0);
        step(1, 0, 0, 5'b0, 5'b0);
        chk("start_in_run_time_left", int'(time_left), 5);
        chk("start_in_run_score", int'(score), 1);
        step(0, 0, 0, 5'b0, 5'b10000);
`ifdef MISS_PENALTY_EN
        chk("penalty_score", int'(score), 0);
        step(0, 0, 0, 5'b0, 5'b10000);
        chk("penalty_floor_score", int'(score), 0);
`else
        chk("unlit_press_score", int'(score), 1);
`endif

        // Mid-round reset
        rst = 1;
        step(0, 1, 1, 5'b11111, 5'b0);
        step(1, 1, 1, 5'b11111, 5'b0);
        rst = 0;
        chk("midrst_lamp", int'(lamp), 0);
        chk("midrst_time_left", int'(time_left), 0);
        chk("midrst_score", int'(score), 0);

        // Randomized phase, checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            rst     = ($urandom_range(0, 599) == 0);
            start   = ($urandom_range(0, 24) == 0);
            tick    = ($urandom_range(0, 2) == 0);
            spawn_t = $urandom_range(0, 1) == 1;
            prn     = 5'($urandom);
            btn     = 5'($urandom & $urandom & $urandom);
            @(negedge clk);
        end
        rst = 0; start = 0; tick = 0; spawn_t = 0; prn = 0; btn = 0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
